// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, ALU op encoding and ID/EX register layout
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // {funct7[5], funct3}
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_ctrl_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [3:0]        alu_ctrl;
        logic              src_imm;
        logic              src_pc;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - operand bypass select, EX/MEM over MEM/WB over register data
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   reg_data,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [XLEN-1:0]   mwb_result,
    output logic [XLEN-1:0]   data
);

    logic exm_hit;
    logic mwb_hit;

    // x0 is hard-wired zero, so a producer targeting it never bypasses
    assign exm_hit = exm_reg_write && (exm_rd != '0) && (exm_rd == rs);
    assign mwb_hit = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs);

    always_comb begin
        data = reg_data;
        if (exm_hit) begin
            data = exm_result;
        end else if (mwb_hit) begin
            data = mwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use detection and operand bypass
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_src_imm,
    input  logic              id_src_pc,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [XLEN-1:0]   mwb_result,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [XLEN-1:0]   ex_pc
);

    id_ex_t          q;
    id_ex_t          d;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign load_use_stall = id_valid && q.valid && q.mem_read && (q.rd != '0) &&
                            ((id_rs1 == q.rd) || (id_rs2 == q.rd));

    // Regfile write and read happen in the same cycle, so capture the retiring value directly
    always_comb begin
        d           = '0;
        d.valid     = id_valid;
        d.pc        = id_pc;
        d.imm       = id_imm;
        d.rs1       = id_rs1;
        d.rs2       = id_rs2;
        d.rd        = id_rd;
        d.alu_ctrl  = id_alu_ctrl;
        d.src_imm   = id_src_imm;
        d.src_pc    = id_src_pc;
        d.reg_write = id_valid && id_reg_write;
        d.mem_read  = id_valid && id_mem_read;
        d.mem_write = id_valid && id_mem_write;
        d.rs1_data  = (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == id_rs1)) ? mwb_result
                                                                              : id_rs1_data;
        d.rs2_data  = (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == id_rs2)) ? mwb_result
                                                                              : id_rs2_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush_i || (!stall_i && load_use_stall)) begin
            q.valid     <= 1'b0;
            q.reg_write <= 1'b0;
            q.mem_read  <= 1'b0;
            q.mem_write <= 1'b0;
        end else if (stall_i) begin
            // Refresh operands so a producer retiring during the hold is not lost
            q.rs1_data <= fwd_rs1;
            q.rs2_data <= fwd_rs2;
        end else begin
            q <= d;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs            (q.rs1),
        .reg_data      (q.rs1_data),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .data          (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs            (q.rs2),
        .reg_data      (q.rs2_data),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .data          (fwd_rs2)
    );

    assign alu_a         = q.src_pc  ? q.pc  : fwd_rs1;
    assign alu_b         = q.src_imm ? q.imm : fwd_rs2;
    assign alu_ctrl      = q.alu_ctrl;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = q.valid;
    assign ex_rd         = q.rd;
    assign ex_reg_write  = q.reg_write;
    assign ex_mem_read   = q.mem_read;
    assign ex_mem_write  = q.mem_write;
    assign ex_pc         = q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [3:0]        id_alu_ctrl;
    logic              id_src_imm;
    logic              id_src_pc;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              exm_reg_write;
    logic [REG_AW-1:0] exm_rd;
    logic [XLEN-1:0]   exm_result;
    logic              mwb_reg_write;
    logic [REG_AW-1:0] mwb_rd;
    logic [XLEN-1:0]   mwb_result;
    logic              stall_i;
    logic              flush_i;
    logic              load_use_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [3:0]        alu_ctrl;
    logic [XLEN-1:0]   ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [XLEN-1:0]   ex_pc;

    int errors = 0;
    int checks = 0;

    id_ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_alu_ctrl    (id_alu_ctrl),
        .id_src_imm     (id_src_imm),
        .id_src_pc      (id_src_pc),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .exm_reg_write  (exm_reg_write),
        .exm_rd         (exm_rd),
        .exm_result     (exm_result),
        .mwb_reg_write  (mwb_reg_write),
        .mwb_rd         (mwb_rd),
        .mwb_result     (mwb_result),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .load_use_stall (load_use_stall),
        .ex_valid       (ex_valid),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_ctrl       (alu_ctrl),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_pc          (ex_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_ctrl = 0;
        id_src_imm = 0; id_src_pc = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
        stall_i = 0; flush_i = 0;
    endtask

    initial begin
        rst_n = 0;
        idle();

        // reset with a valid instruction offered
        id_valid = 1; id_rs1_data = 32'h1111; id_rs2_data = 32'h2222; id_alu_ctrl = ALU_SUB;
        id_reg_write = 1;
        tick();
        expect_eq("rst_ex_valid", 32'(ex_valid), 0);
        expect_eq("rst_alu_a", alu_a, 0);
        expect_eq("rst_alu_b", alu_b, 0);
        expect_eq("rst_alu_ctrl", 32'(alu_ctrl), 0);
        expect_eq("rst_reg_write", 32'(ex_reg_write), 0);
        rst_n = 1;

        // EX/MEM bypass, and priority over MEM/WB
        idle();
        id_valid = 1; id_rs1 = 5; id_rs1_data = 0; id_rs2 = 6; id_rs2_data = 32'h55;
        id_rd = 8; id_reg_write = 1; id_alu_ctrl = ALU_ADD;
        tick();
        idle();
        exm_reg_write = 1; exm_rd = 5; exm_result = 32'h1234;
        #1;
        expect_eq("exm_fwd_alu_a", alu_a, 32'h1234);
        expect_eq("exm_fwd_alu_b", alu_b, 32'h55);
        expect_eq("exm_fwd_valid", 32'(ex_valid), 1);
        mwb_reg_write = 1; mwb_rd = 5; mwb_result = 32'hBEEF;
        #1;
        expect_eq("exm_over_mwb", alu_a, 32'h1234);
        exm_reg_write = 0;
        #1;
        expect_eq("mwb_fwd_alu_a", alu_a, 32'hBEEF);

        // x0 guard
        idle();
        id_valid = 1; id_rs1 = 0; id_rs1_data = 0;
        exm_reg_write = 1; exm_rd = 0; exm_result = 32'hFFFFFFFF;
        tick();
        expect_eq("x0_guard", alu_a, 0);

        // write-through at capture
        idle();
        id_valid = 1; id_rs1 = 9; id_rs1_data = 32'h11;
        mwb_reg_write = 1; mwb_rd = 9; mwb_result = 32'h99;
        tick();
        idle();
        #1;
        expect_eq("write_through", alu_a, 32'h99);

        // operand select: pc and immediate
        idle();
        id_valid = 1; id_pc = 32'h100; id_src_pc = 1; id_src_imm = 1; id_imm = 32'hFFFFFFF0;
        id_rs2 = 2; id_rs2_data = 32'h22; id_alu_ctrl = ALU_SUB;
        tick();
        expect_eq("sel_alu_a_pc", alu_a, 32'h100);
        expect_eq("sel_alu_b_imm", alu_b, 32'hFFFFFFF0);
        expect_eq("sel_store_data", ex_store_data, 32'h22);
        expect_eq("sel_alu_ctrl", 32'(alu_ctrl), 32'(ALU_SUB));
        expect_eq("sel_ex_pc", ex_pc, 32'h100);

        // load-use: lw x7 in EX, dependent on rs2
        idle();
        id_valid = 1; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
        tick();
        expect_eq("lw_mem_read", 32'(ex_mem_read), 1);
        idle();
        id_valid = 1; id_rs1 = 1; id_rs2 = 7; id_rd = 10; id_reg_write = 1;
        #1;
        expect_eq("lu_stall", 32'(load_use_stall), 1);
        tick();
        expect_eq("lu_bubble_valid", 32'(ex_valid), 0);
        expect_eq("lu_bubble_mem_read", 32'(ex_mem_read), 0);
        expect_eq("lu_stall_clear", 32'(load_use_stall), 0);
        tick();
        expect_eq("lu_capture_valid", 32'(ex_valid), 1);
        expect_eq("lu_capture_rd", 32'(ex_rd), 10);

        // flush and stall together
        idle();
        id_valid = 1; id_rd = 4; id_reg_write = 1; id_alu_ctrl = ALU_ADD;
        tick();
        expect_eq("fl_pre_valid", 32'(ex_valid), 1);
        stall_i = 1; flush_i = 1;
        tick();
        expect_eq("fl_valid", 32'(ex_valid), 0);
        expect_eq("fl_reg_write", 32'(ex_reg_write), 0);

        // stall refresh from a retiring MEM/WB producer
        idle();
        id_valid = 1; id_rs1 = 3; id_rs1_data = 0; id_rd = 5; id_reg_write = 1;
        tick();
        id_rs1 = 4; id_rs1_data = 32'h77; id_rd = 6;
        stall_i = 1; mwb_reg_write = 1; mwb_rd = 3; mwb_result = 32'd42;
        tick();
        tick();
        stall_i = 0; mwb_reg_write = 0; mwb_result = 0;
        #1;
        expect_eq("stall_refresh_a", alu_a, 32'd42);
        expect_eq("stall_hold_rd", 32'(ex_rd), 5);
        expect_eq("stall_hold_valid", 32'(ex_valid), 1);

        // reset wins over stall and flush
        idle();
        id_valid = 1; id_rs1_data = 32'h5; stall_i = 1; flush_i = 1; rst_n = 0;
        tick();
        expect_eq("rst_mid_valid", 32'(ex_valid), 0);
        expect_eq("rst_mid_alu_a", alu_a, 0);
        expect_eq("rst_mid_rd", 32'(ex_rd), 0);
        rst_n = 1;
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
